// File: rtl/program_loader.sv
// Boot-time program loader: captures a 4-byte little-endian program size from the
// UART byte stream, then packs the following bytes into 32-bit words for program memory.
module program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              receive_size,
    input  logic              receive_data,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              size_finished,
    output logic              data_finished,
    output logic              size_error,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [31:0]       pm_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        SIZE,
        WAIT_DATA,
        DATA,
        DONE,
        ERROR
    } state_t;

    // Capacity in bytes; one extra bit so 2**ADDR_W words of 4 bytes never overflows.
    localparam logic [32:0] CAPACITY = 33'd4 << ADDR_W;

    state_t            state;
    state_t            state_next;
    logic [31:0]       size;
    logic [31:0]       byte_cnt;
    logic [31:0]       word;
    logic [31:0]       word_next;
    logic [ADDR_W-1:0] word_addr;
    logic              last_write;

    logic              size_load;
    logic              size_done;
    logic              data_load;
    logic              word_done;
    logic              zero_done;
    logic              set_error;
    logic              last_byte;
    logic              too_big;

    assign last_byte = (byte_cnt + 32'd1) == size;
    assign too_big   = {1'b0, size} > CAPACITY;

    // Word under construction with the incoming byte merged in; unfilled lanes stay zero.
    always_comb begin
        word_next = word;
        word_next[8*byte_cnt[1:0] +: 8] = rx_data;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        size_load  = 1'b0;
        size_done  = 1'b0;
        data_load  = 1'b0;
        word_done  = 1'b0;
        zero_done  = 1'b0;
        set_error  = 1'b0;
        case (state)
            IDLE: begin
                if (receive_size) state_next = SIZE;
            end
            SIZE: begin
                if (rx_valid) begin
                    size_load = 1'b1;
                    if (byte_cnt[1:0] == 2'd3) begin
                        size_done  = 1'b1;
                        state_next = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (too_big) begin
                    set_error  = 1'b1;
                    state_next = ERROR;
                end else if (receive_data) begin
                    if (size == 32'd0) begin
                        zero_done  = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    data_load = 1'b1;
                    word_done = (byte_cnt[1:0] == 2'd3) || last_byte;
                    if (last_byte) state_next = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            size          <= '0;
            byte_cnt      <= '0;
            word          <= '0;
            word_addr     <= '0;
            last_write    <= 1'b0;
            size_finished <= 1'b0;
            data_finished <= 1'b0;
            size_error    <= 1'b0;
            pm_we         <= 1'b0;
            pm_addr       <= '0;
            pm_wdata      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pm_we      <= 1'b0;
            last_write <= data_load && last_byte;

            if (size_load) begin
                size[8*byte_cnt[1:0] +: 8] <= rx_data;
                byte_cnt <= size_done ? 32'd0 : byte_cnt + 32'd1;
            end
            if (size_done)               size_finished <= 1'b1;
            if (set_error)               size_error    <= 1'b1;
            if (zero_done || last_write) data_finished <= 1'b1;

            if (data_load) begin
                byte_cnt <= byte_cnt + 32'd1;
                if (word_done) begin
                    pm_we     <= 1'b1;
                    pm_addr   <= word_addr;
                    pm_wdata  <= word_next;
                    word_addr <= word_addr + ADDR_W'(1);
                    word      <= '0;
                end else begin
                    word      <= word_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default instance (ADDR_W=10) and a small
// instance (ADDR_W=4) share stimulus; expected words are hand-computed constants.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       receive_size = 1'b0;
    logic       receive_data = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic        size_finished, data_finished, size_error, pm_we;
    logic [9:0]  pm_addr;
    logic [31:0] pm_wdata;

    logic        s_size_finished, s_data_finished, s_size_error, s_pm_we;
    logic [3:0]  s_pm_addr;
    logic [31:0] s_pm_wdata;

    int errors = 0;
    int checks = 0;
    int we_count = 0;
    int s_we_count = 0;

    logic [7:0] pay [8];

    program_loader #(.ADDR_W(10)) dut (
        .clk(clk), .reset_n(reset_n), .receive_size(receive_size), .receive_data(receive_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .size_finished(size_finished),
        .data_finished(data_finished), .size_error(size_error), .pm_we(pm_we),
        .pm_addr(pm_addr), .pm_wdata(pm_wdata)
    );

    program_loader #(.ADDR_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .receive_size(receive_size), .receive_data(receive_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .size_finished(s_size_finished),
        .data_finished(s_data_finished), .size_error(s_size_error), .pm_we(s_pm_we),
        .pm_addr(s_pm_addr), .pm_wdata(s_pm_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pm_we)   we_count++;
        if (s_pm_we) s_we_count++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset;
        reset_n      = 1'b0;
        receive_size = 1'b0;
        receive_data = 1'b0;
        rx_valid     = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    // receive_size rises together with a junk byte that must be ignored.
    task automatic start_size;
        receive_size = 1'b1;
        rx_valid     = 1'b1;
        rx_data      = 8'hFF;
        tick();
        receive_size = 1'b0;
        rx_valid     = 1'b0;
    endtask

    task automatic send_size(input string tag, input logic [31:0] sz);
        for (int i = 0; i < 4; i++) begin
            send_byte(sz[8*i +: 8]);
            checks++;
            if (size_finished !== (i == 3)) begin
                errors++;
                $display("FAIL %s_size_finished_b%0d: got %b want %b", tag, i, size_finished, (i == 3));
            end
        end
    endtask

    task automatic start_data;
        receive_data = 1'b1;
        rx_valid     = 1'b1;
        rx_data      = 8'h77;
        tick();
        receive_data = 1'b0;
        rx_valid     = 1'b0;
    endtask

    // Full size + data load of n payload bytes from pay[], checking each write at N+1.
    task automatic run_load(input string tag, input logic [31:0] sz, input int n,
                            input logic [31:0] w0, input logic [31:0] w1);
        int base;
        logic exp_we;
        logic [31:0] exp_w;
        base = we_count;
        start_size();
        send_size(tag, sz);
        start_data();
        for (int i = 0; i < n; i++) begin
            send_byte(pay[i]);
            exp_we = (i % 4 == 3) || (i == n - 1);
            exp_w  = (i < 4) ? w0 : w1;
            checks++;
            if (pm_we !== exp_we) begin
                errors++;
                $display("FAIL %s_we_b%0d: got %b want %b", tag, i, pm_we, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (pm_addr !== 10'(i / 4) || pm_wdata !== exp_w) begin
                    errors++;
                    $display("FAIL %s_write_b%0d: got addr=%0d data=%h want addr=%0d data=%h",
                             tag, i, pm_addr, pm_wdata, i / 4, exp_w);
                end
                checks++;
                if (data_finished !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early_finish_b%0d: got %b want 0", tag, i, data_finished);
                end
            end
        end
        tick();
        checks++;
        if (data_finished !== 1'b1 || pm_we !== 1'b0) begin
            errors++;
            $display("FAIL %s_finish: got data_finished=%b pm_we=%b want 1 0", tag, data_finished, pm_we);
        end
        checks++;
        if (pm_addr !== 10'((n - 1) / 4) || pm_wdata !== ((n > 4) ? w1 : w0)) begin
            errors++;
            $display("FAIL %s_hold: got addr=%0d data=%h", tag, pm_addr, pm_wdata);
        end
        checks++;
        if (we_count - base !== (n + 3) / 4) begin
            errors++;
            $display("FAIL %s_we_pulses: got %0d want %0d", tag, we_count - base, (n + 3) / 4);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        checks++;
        if ({size_finished, data_finished, size_error, pm_we} !== 4'b0 || pm_addr !== 10'd0 ||
            pm_wdata !== 32'd0 || {s_size_finished, s_data_finished, s_size_error, s_pm_we} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b%b%b we=%b addr=%0d data=%h want all 0",
                     size_finished, data_finished, size_error, pm_we, pm_addr, pm_wdata);
        end
        do_reset();
    endtask

    task automatic test_basic_load;
        do_reset();
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load("t1", 32'd8, 8, 32'h0000_0013, 32'h0010_0093);
    endtask

    task automatic test_partial_word;
        do_reset();
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h00};
        run_load("t2", 32'd6, 6, 32'hDDCC_BBAA, 32'h0000_FFEE);
    endtask

    task automatic test_zero_size;
        int base;
        do_reset();
        base = we_count;
        start_size();
        send_size("t3", 32'd0);
        receive_data = 1'b1;
        tick();
        receive_data = 1'b0;
        checks++;
        if (data_finished !== 1'b1) begin
            errors++;
            $display("FAIL t3_finish: got %b want 1", data_finished);
        end
        send_byte(8'h5A);
        repeat (3) tick();
        checks++;
        if (we_count != base) begin
            errors++;
            $display("FAIL t3_no_write: got %0d pulses want 0", we_count - base);
        end
    endtask

    task automatic test_capacity;
        int base;
        do_reset();
        base = s_we_count;
        start_size();
        send_size("t4", 32'd68);
        checks++;
        if (s_size_finished !== 1'b1) begin
            errors++;
            $display("FAIL t4_small_size_finished: got %b want 1", s_size_finished);
        end
        tick();
        checks++;
        if (s_size_error !== 1'b1 || size_error !== 1'b0) begin
            errors++;
            $display("FAIL t4_size_error: got small=%b big=%b want 1 0", s_size_error, size_error);
        end
        start_data();
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
        repeat (2) tick();
        checks++;
        if (s_we_count != base || s_data_finished !== 1'b0 || s_size_error !== 1'b1) begin
            errors++;
            $display("FAIL t4_abort: got pulses=%0d data_finished=%b size_error=%b want 0 0 1",
                     s_we_count - base, s_data_finished, s_size_error);
        end
        // Exactly at capacity (64 bytes for ADDR_W=4) is accepted.
        do_reset();
        start_size();
        send_size("t4b", 32'd64);
        repeat (2) tick();
        checks++;
        if (s_size_error !== 1'b0 || s_size_finished !== 1'b1) begin
            errors++;
            $display("FAIL t4_at_capacity: got size_error=%b size_finished=%b want 0 1",
                     s_size_error, s_size_finished);
        end
    endtask

    task automatic test_ignored_bytes;
        int base;
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        checks++;
        if (pm_we !== 1'b0 || size_finished !== 1'b0) begin
            errors++;
            $display("FAIL t5_idle: got pm_we=%b size_finished=%b want 0 0", pm_we, size_finished);
        end
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load("t5", 32'd4, 4, 32'h0403_0201, 32'h0);
        base = we_count;
        for (int i = 0; i < 4; i++) send_byte(8'h55 + 8'(i));
        tick();
        checks++;
        if (we_count != base || pm_addr !== 10'd0 || pm_wdata !== 32'h0403_0201 || data_finished !== 1'b1) begin
            errors++;
            $display("FAIL t5_done: got pulses=%0d addr=%0d data=%h finished=%b",
                     we_count - base, pm_addr, pm_wdata, data_finished);
        end
    endtask

    task automatic test_reset_mid_load;
        do_reset();
        start_size();
        send_size("t6a", 32'd8);
        start_data();
        send_byte(8'h13);
        send_byte(8'h00);
        reset_n = 1'b0;
        tick();
        checks++;
        if (size_finished !== 1'b0 || pm_we !== 1'b0 || pm_addr !== 10'd0 || pm_wdata !== 32'd0) begin
            errors++;
            $display("FAIL t6_reset: got size_finished=%b pm_we=%b addr=%0d data=%h want 0",
                     size_finished, pm_we, pm_addr, pm_wdata);
        end
        reset_n = 1'b1;
        tick();
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load("t6", 32'd8, 8, 32'h0000_0013, 32'h0010_0093);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial_word();
        test_zero_size();
        test_capacity();
        test_ignored_bytes();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
